rtc_rgs_mc: RTL and testbench
=============================

# rtc_rgs_mc

Multi-channel successor of the RTC software register block: a 32-bit on-chip-bus slave that programs RTC tick, offset and PPS controls. It adds NUM_PTS independent PPS/event timestamp channels, each with a FIFO. Reading the current time and each timestamp uses a coherent multi-word snapshot. Status bits are write-one-to-clear and drive an interrupt output. It sits between the bus bridge and the RTC core / PPS capture logic.

## Interface
- BLK_ADDR, `RTC_BLK_ADDR: 24-bit block base, matched against bus2ip_addr_i[31:8].
- NUM_PTS, 2: timestamp channels, 1..4.
- FIFO_DEPTH, 4: entries per channel FIFO, power of 2, 2..16.
- bus2ip_clk  in  1  clock.
- bus2ip_rst_n  in  1  reset, asynchronous, active-low.
- bus2ip_addr_i  in  32  byte address.
- bus2ip_data_i  in  32  write data.
- bus2ip_rd_ce_i  in  1  read enable, active high, may be held for several cycles.
- bus2ip_wr_ce_i  in  1  write enable, active high.
- ip2bus_data_o  out  32  registered read data.
- rtc_std_i  in  80  current time {sec[47:0], ns[31:0]}.
- rtc_fns_i  in  16  current fractional ns.
- pts_std_i  in  80*NUM_PTS  channel timestamps; channel c occupies bits [80c+79:80c].
- pts_fns_i  in  16*NUM_PTS  channel fractional ns.
- pts_valid_i  in  NUM_PTS  one-cycle capture strobe per channel.
- tick_inc_o  out  32  tick increment.
- ns_offset_o  out  32  ns offset.
- sc_offset_o  out  48  seconds offset.
- offset_valid_o  out  1  one-cycle offset-apply pulse.
- clear_rtc_o  out  1  one-cycle RTC clear pulse.
- pps_width_o  out  32  PPS width.
- intxms_sel_o  out  1  interval select: 0 = 10 ms, 1 = 7.8125 ms.
- irq_o  out  1  registered interrupt, level.

## Operation
Register map (offset = addr[7:0]):
- 0x00 CTL: bit0 offset_valid, bit1 clear_rtc, bit2 intxms_sel.
- 0x04 TICK_INC.
- 0x08 NS_OFST.
- 0x0C SC_OFST0 = sc[47:32] in bits [15:0].
- 0x10 SC_OFST1 = sc[31:0].
- 0x14/0x18/0x1C CUR_TM0/1/2 = sec[47:16], {sec[15:0], ns[31:16]}, {ns[15:0], fns}. This is the same 96-bit packing as the timestamp words.
- 0x20 PPS_W.
- 0x24 IRQ_STAT: bit c = channel c FIFO non-empty (read-only, live). Bit 4+c = channel c overflow, sticky, W1C.
- 0x28 IRQ_EN: bits [7:0], R/W.
- 0x40+0x10c, channel c: +0 TS0, +4 TS1, +8 TS2, +C STAT = {overflow in bit 8, level in bits [4:0]}.
- Unmapped offsets and channels c ≥ NUM_PTS read 0 and ignore writes.

Read side effects occur only on a read-start cycle, defined as rd_ce & ~rd_ce_prev with the address matching:
- CUR_TM0 start: latch {rtc_std_i, rtc_fns_i} into a 96-bit shadow. CUR_TM0 returns the latched sec[47:16]. CUR_TM1/2 return shadow bits.
- TS0 start, FIFO non-empty: copy the head entry into the channel shadow and pop. TS0 returns head bits [95:64].
- TS0 start, FIFO empty: shadow unchanged, TS0 returns 0, no pop.
- TS1/TS2 return shadow bits.

CTL self-clearing bits:
- A write of 1 sets the bit. The matching output pulses high for exactly one cycle, in the cycle after the write.
- The bit reads back 1 and clears 2 cycles after the write unless it is rewritten.
- Writing 0 has no effect on a pending pulse.

FIFO behaviour:
- pts_valid_i[c] pushes {pts_std, pts_fns}.
- Push while full: entry dropped, overflow set.
- Push and pop in the same cycle while full: both succeed, no overflow.
- Push and pop in the same cycle while empty: the pop returns empty (TS0 = 0), the push is stored.
- W1C of an overflow bit in the same cycle as a new overflow: the bit stays set.

Interrupt: irq_o <= |(IRQ_STAT[7:0] & IRQ_EN).

## Timing
- ip2bus_data_o is registered: data for a read cycle appears on the next edge.
- Write effects are visible on the next edge.
- Pushes update level one cycle after pts_valid_i. irq_o follows one further cycle later.
- Reset values:
  - All outputs 0, including tick_inc_o, ns_offset_o, sc_offset_o, pps_width_o and irq_o.
  - FIFOs empty, shadows 0, IRQ_EN 0.
- Reset in the middle of a pending pulse: the pulse is cancelled.
- Reset during a FIFO read: FIFO contents are discarded.
- If rd_ce and wr_ce are both asserted in the same cycle, both are processed and the read returns the pre-write value.

## Structure
- Register offsets, bit positions and the 96-bit timestamp packing are defined in ptpv2_defines.v.
- Sub-module rtc_pts_fifo provides one FIFO per channel, instantiated NUM_PTS times via generate.
  - Ports: push, din[95:0], pop, dout, level, full, empty, overflow_set.
  - Registered pointers with an extra wrap bit.

## Test plan
- Reset, then read every register -> all 0.
- Write CTL=0x3 -> offset_valid_o and clear_rtc_o each high for exactly 1 cycle. CTL reads 0x3 on the next read and 0x0 after 2 cycles.
- Snapshot: hold rtc_std_i at sec=0x123456789ABC, ns=0x11223344, fns=0x5566, read CUR_TM0, change the inputs, then read CUR_TM1/2:
  - CUR_TM0 = 0x12345678.
  - CUR_TM1 = 0x9ABC1122.
  - CUR_TM2 = 0x33445566.
- Channel 1: push 5 events with FIFO_DEPTH=4 -> STAT = 0x104. Four pops return events 1..4 in order. A fifth TS0 read returns 0 and level stays 0.
- IRQ_EN=0x01, push on channel 0 -> irq_o=1 two cycles after the strobe. Draining the FIFO -> irq_o=0.
- Hold rd_ce on TS0 for 3 cycles -> exactly one pop.
- Simultaneous push and pop on a full FIFO -> level stays 4, overflow clear.

Source files
------------

// File: rtl/rtc_rgs_mc_pkg.sv
// Shared register map, timestamp packing and decode helpers for the RTC register block.
package rtc_rgs_mc_pkg;

    // Default block base, matched against bus address bits [31:8].
    localparam logic [23:0] RtcBlkAddr = 24'h00_C000;

    // Register byte offsets within the block.
    localparam logic [7:0] OffCtl     = 8'h00;
    localparam logic [7:0] OffTickInc = 8'h04;
    localparam logic [7:0] OffNsOfst  = 8'h08;
    localparam logic [7:0] OffScOfst0 = 8'h0C;
    localparam logic [7:0] OffScOfst1 = 8'h10;
    localparam logic [7:0] OffCurTm0  = 8'h14;
    localparam logic [7:0] OffCurTm1  = 8'h18;
    localparam logic [7:0] OffCurTm2  = 8'h1C;
    localparam logic [7:0] OffPpsW    = 8'h20;
    localparam logic [7:0] OffIrqStat = 8'h24;
    localparam logic [7:0] OffIrqEn   = 8'h28;

    // CTL bit positions.
    localparam int unsigned CtlOfsVldBit = 0;
    localparam int unsigned CtlClrRtcBit = 1;
    localparam int unsigned CtlIntxmsBit = 2;

    // Width of the per-channel FIFO level field.
    localparam int unsigned LvlW = 5;

    // 96-bit timestamp: {sec[47:0], ns[31:0], fns[15:0]}.
    typedef logic [95:0] ts_t;

    typedef enum logic [3:0] {
        RegNone,
        RegCtl,
        RegTickInc,
        RegNsOfst,
        RegScOfst0,
        RegScOfst1,
        RegCurTm0,
        RegCurTm1,
        RegCurTm2,
        RegPpsW,
        RegIrqStat,
        RegIrqEn,
        RegChan
    } reg_sel_e;

    function automatic ts_t ts_pack(input logic [79:0] std, input logic [15:0] fns);
        return {std, fns};
    endfunction

    // Word 0 is the most significant 32 bits of the packed timestamp.
    function automatic logic [31:0] ts_word(input ts_t ts, input logic [1:0] idx);
        logic [31:0] w;
        case (idx)
            2'd0:    w = ts[95:64];
            2'd1:    w = ts[63:32];
            default: w = ts[31:0];
        endcase
        return w;
    endfunction

    // Misaligned offsets decode to nothing; 0x40..0x7F is the channel window.
    function automatic reg_sel_e reg_decode(input logic [7:0] off);
        reg_sel_e sel;
        sel = RegNone;
        if (off[1:0] == 2'b00) begin
            if (off[7:6] == 2'b01) begin
                sel = RegChan;
            end else begin
                case (off)
                    OffCtl:     sel = RegCtl;
                    OffTickInc: sel = RegTickInc;
                    OffNsOfst:  sel = RegNsOfst;
                    OffScOfst0: sel = RegScOfst0;
                    OffScOfst1: sel = RegScOfst1;
                    OffCurTm0:  sel = RegCurTm0;
                    OffCurTm1:  sel = RegCurTm1;
                    OffCurTm2:  sel = RegCurTm2;
                    OffPpsW:    sel = RegPpsW;
                    OffIrqStat: sel = RegIrqStat;
                    OffIrqEn:   sel = RegIrqEn;
                    default:    sel = RegNone;
                endcase
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/rtc_pts_fifo.sv
// Per-channel timestamp FIFO with wrap-bit pointers and overflow reporting.
module rtc_pts_fifo
    import rtc_rgs_mc_pkg::*;
#(
    parameter int unsigned Depth = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            push_i,
    input  ts_t             din_i,
    input  logic            pop_i,
    output ts_t             dout_o,
    output logic [LvlW-1:0] level_o,
    output logic            full_o,
    output logic            empty_o,
    output logic            overflow_set_o
);

    localparam int unsigned AddrW = $clog2(Depth);

    logic [AddrW:0] wr_ptr_q, wr_ptr_d;
    logic [AddrW:0] rd_ptr_q, rd_ptr_d;
    logic [AddrW:0] count;
    logic           push_ok, pop_ok;
    ts_t            mem_q [Depth];

    assign count   = wr_ptr_q - rd_ptr_q;
    assign full_o  = (count == (AddrW + 1)'(Depth));
    assign empty_o = (count == '0);
    assign level_o = LvlW'(count);
    assign dout_o  = mem_q[rd_ptr_q[AddrW-1:0]];

    // A pop frees the head slot this cycle, so a push into a full FIFO still lands.
    assign pop_ok         = pop_i & ~empty_o;
    assign push_ok        = push_i & (~full_o | pop_ok);
    assign overflow_set_o = push_i & full_o & ~pop_ok;

    // Pointer advance.
    always_comb begin
        wr_ptr_d = wr_ptr_q + (AddrW + 1)'(push_ok);
        rd_ptr_d = rd_ptr_q + (AddrW + 1)'(pop_ok);
    end

    // Pointer registers; reset discards contents.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage; only slots between the pointers are ever observed.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AddrW-1:0]] <= din_i;
        end
    end

endmodule

// File: rtl/rtc_rgs_mc.sv
// Multi-channel RTC register block: control/offset registers, coherent time snapshot,
// per-channel timestamp FIFOs and a level interrupt.
module rtc_rgs_mc
    import rtc_rgs_mc_pkg::*;
#(
    parameter logic [23:0] BLK_ADDR   = RtcBlkAddr,
    parameter int unsigned NUM_PTS    = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  bus2ip_clk,
    input  logic                  bus2ip_rst_n,
    input  logic [31:0]           bus2ip_addr_i,
    input  logic [31:0]           bus2ip_data_i,
    input  logic                  bus2ip_rd_ce_i,
    input  logic                  bus2ip_wr_ce_i,
    output logic [31:0]           ip2bus_data_o,
    input  logic [79:0]           rtc_std_i,
    input  logic [15:0]           rtc_fns_i,
    input  logic [80*NUM_PTS-1:0] pts_std_i,
    input  logic [16*NUM_PTS-1:0] pts_fns_i,
    input  logic [NUM_PTS-1:0]    pts_valid_i,
    output logic [31:0]           tick_inc_o,
    output logic [31:0]           ns_offset_o,
    output logic [47:0]           sc_offset_o,
    output logic                  offset_valid_o,
    output logic                  clear_rtc_o,
    output logic [31:0]           pps_width_o,
    output logic                  intxms_sel_o,
    output logic                  irq_o
);

    reg_sel_e    sel;
    logic        blk_hit, rd_start, wr_en, ch_ok;
    logic [1:0]  ch_idx, ch_word;
    logic        wr_ctl, wr_stat;

    logic        rd_prev_q;
    logic [1:0]  ctl_q, ctl_d, age_q, age_d, pulse_q, pulse_d;
    logic        intxms_q;
    logic [31:0] tick_q, ns_q, pps_q, rdata_q;
    logic [47:0] sc_q;
    logic [7:0]  irq_en_q;
    logic        irq_q;
    logic [NUM_PTS-1:0] ovf_q, ovf_d;
    ts_t         cur_shadow_q;
    ts_t         ts_shadow_q [NUM_PTS];

    ts_t             fifo_dout  [NUM_PTS];
    logic [LvlW-1:0] fifo_level [NUM_PTS];
    logic [NUM_PTS-1:0] fifo_full, fifo_empty, fifo_ovf_set, fifo_pop;

    ts_t             sel_dout, sel_shadow;
    logic            sel_empty, sel_ovf;
    logic [LvlW-1:0] sel_level;
    logic [7:0]      irq_stat;
    logic [31:0]     rdata;

    assign blk_hit  = (bus2ip_addr_i[31:8] == BLK_ADDR);
    assign sel      = blk_hit ? reg_decode(bus2ip_addr_i[7:0]) : RegNone;
    assign ch_idx   = bus2ip_addr_i[5:4];
    assign ch_word  = bus2ip_addr_i[3:2];
    assign ch_ok    = (sel == RegChan) && (32'(ch_idx) < NUM_PTS);
    // Side effects fire only on the first cycle of a (possibly held) read.
    assign rd_start = bus2ip_rd_ce_i & ~rd_prev_q & blk_hit;
    assign wr_en    = bus2ip_wr_ce_i & blk_hit;
    assign wr_ctl   = wr_en && (sel == RegCtl);
    assign wr_stat  = wr_en && (sel == RegIrqStat);

    for (genvar c = 0; c < NUM_PTS; c++) begin : g_ch
        assign fifo_pop[c] = rd_start & ch_ok & (ch_idx == 2'(c)) & (ch_word == 2'd0);

        rtc_pts_fifo #(
            .Depth (FIFO_DEPTH)
        ) u_fifo (
            .clk_i          (bus2ip_clk),
            .rst_ni         (bus2ip_rst_n),
            .push_i         (pts_valid_i[c]),
            .din_i          (ts_pack(pts_std_i[80*c +: 80], pts_fns_i[16*c +: 16])),
            .pop_i          (fifo_pop[c]),
            .dout_o         (fifo_dout[c]),
            .level_o        (fifo_level[c]),
            .full_o         (fifo_full[c]),
            .empty_o        (fifo_empty[c]),
            .overflow_set_o (fifo_ovf_set[c])
        );

        a_ovf_only_when_full : assert property (@(posedge bus2ip_clk) disable iff (!bus2ip_rst_n)
            fifo_ovf_set[c] |-> fifo_full[c]);
    end

    // Select the addressed channel's FIFO/shadow state and build the live status word.
    always_comb begin
        sel_dout   = '0;
        sel_shadow = '0;
        sel_empty  = 1'b1;
        sel_ovf    = 1'b0;
        sel_level  = '0;
        irq_stat   = '0;
        for (int c = 0; c < NUM_PTS; c++) begin
            irq_stat[c]     = ~fifo_empty[c];
            irq_stat[4 + c] = ovf_q[c];
            if (ch_idx == 2'(c)) begin
                sel_dout   = fifo_dout[c];
                sel_shadow = ts_shadow_q[c];
                sel_empty  = fifo_empty[c];
                sel_ovf    = ovf_q[c];
                sel_level  = fifo_level[c];
            end
        end
    end

    // Read data mux; always reflects pre-write register state.
    always_comb begin
        rdata = '0;
        unique case (sel)
            RegCtl:     rdata = {29'b0, intxms_q, ctl_q[CtlClrRtcBit], ctl_q[CtlOfsVldBit]};
            RegTickInc: rdata = tick_q;
            RegNsOfst:  rdata = ns_q;
            RegScOfst0: rdata = {16'b0, sc_q[47:32]};
            RegScOfst1: rdata = sc_q[31:0];
            RegCurTm0:  rdata = rd_start ? rtc_std_i[79:48] : ts_word(cur_shadow_q, 2'd0);
            RegCurTm1:  rdata = ts_word(cur_shadow_q, 2'd1);
            RegCurTm2:  rdata = ts_word(cur_shadow_q, 2'd2);
            RegPpsW:    rdata = pps_q;
            RegIrqStat: rdata = {24'b0, irq_stat};
            RegIrqEn:   rdata = {24'b0, irq_en_q};
            RegChan: begin
                if (ch_ok) begin
                    unique case (ch_word)
                        2'd0: begin
                            if (rd_start) rdata = sel_empty ? '0 : ts_word(sel_dout, 2'd0);
                            else          rdata = ts_word(sel_shadow, 2'd0);
                        end
                        2'd1: rdata = ts_word(sel_shadow, 2'd1);
                        2'd2: rdata = ts_word(sel_shadow, 2'd2);
                        default: rdata = {23'b0, sel_ovf, 3'b0, sel_level};
                    endcase
                end
            end
            default: rdata = '0;
        endcase
    end

    // Self-clearing CTL bits: set on write of 1, pulse next cycle, drop two edges later.
    always_comb begin
        ctl_d   = ctl_q;
        age_d   = age_q;
        pulse_d = '0;
        for (int i = 0; i < 2; i++) begin
            if (wr_ctl && bus2ip_data_i[i]) begin
                ctl_d[i]   = 1'b1;
                age_d[i]   = 1'b0;
                pulse_d[i] = 1'b1;
            end else if (ctl_q[i]) begin
                if (age_q[i]) begin
                    ctl_d[i] = 1'b0;
                    age_d[i] = 1'b0;
                end else begin
                    age_d[i] = 1'b1;
                end
            end
        end
    end

    // Sticky overflow: a new overflow wins over a same-cycle W1C.
    always_comb begin
        ovf_d = ovf_q;
        if (wr_stat) ovf_d = ovf_d & ~bus2ip_data_i[4 +: NUM_PTS];
        ovf_d = ovf_d | fifo_ovf_set;
    end

    // Register state, shadows, interrupt and read data.
    always_ff @(posedge bus2ip_clk or negedge bus2ip_rst_n) begin
        if (!bus2ip_rst_n) begin
            rd_prev_q    <= 1'b0;
            ctl_q        <= '0;
            age_q        <= '0;
            pulse_q      <= '0;
            intxms_q     <= 1'b0;
            tick_q       <= '0;
            ns_q         <= '0;
            sc_q         <= '0;
            pps_q        <= '0;
            irq_en_q     <= '0;
            irq_q        <= 1'b0;
            ovf_q        <= '0;
            rdata_q      <= '0;
            cur_shadow_q <= '0;
            for (int c = 0; c < NUM_PTS; c++) ts_shadow_q[c] <= '0;
        end else begin
            rd_prev_q <= bus2ip_rd_ce_i;
            ctl_q     <= ctl_d;
            age_q     <= age_d;
            pulse_q   <= pulse_d;
            ovf_q     <= ovf_d;
            irq_q     <= |(irq_stat & irq_en_q);
            rdata_q   <= bus2ip_rd_ce_i ? rdata : '0;
            if (wr_ctl) intxms_q <= bus2ip_data_i[CtlIntxmsBit];
            if (wr_en && (sel == RegTickInc)) tick_q <= bus2ip_data_i;
            if (wr_en && (sel == RegNsOfst))  ns_q <= bus2ip_data_i;
            if (wr_en && (sel == RegScOfst0)) sc_q[47:32] <= bus2ip_data_i[15:0];
            if (wr_en && (sel == RegScOfst1)) sc_q[31:0] <= bus2ip_data_i;
            if (wr_en && (sel == RegPpsW))    pps_q <= bus2ip_data_i;
            if (wr_en && (sel == RegIrqEn))   irq_en_q <= bus2ip_data_i[7:0];
            if (rd_start && (sel == RegCurTm0)) cur_shadow_q <= ts_pack(rtc_std_i, rtc_fns_i);
            for (int c = 0; c < NUM_PTS; c++) begin
                if (fifo_pop[c] && !fifo_empty[c]) ts_shadow_q[c] <= fifo_dout[c];
            end
        end
    end

    assign ip2bus_data_o  = rdata_q;
    assign tick_inc_o     = tick_q;
    assign ns_offset_o    = ns_q;
    assign sc_offset_o    = sc_q;
    assign pps_width_o    = pps_q;
    assign offset_valid_o = pulse_q[CtlOfsVldBit];
    assign clear_rtc_o    = pulse_q[CtlClrRtcBit];
    assign intxms_sel_o   = intxms_q;
    assign irq_o          = irq_q;

endmodule

// File: tb/tb_rtc_rgs_mc.sv
// Self-checking bench for rtc_rgs_mc: vector tables, timed corner sequences and a
// randomized run against a queue-based reference model.
module tb_rtc_rgs_mc;
    import rtc_rgs_mc_pkg::*;

    localparam int unsigned NPts  = 2;
    localparam int unsigned Depth = 4;
    localparam logic [23:0] Blk   = 24'h00_C000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr, wdata;
    logic        rd_ce, wr_ce;
    logic [31:0] rdata;
    logic [79:0] rtc_std;
    logic [15:0] rtc_fns;
    logic [80*NPts-1:0] pts_std;
    logic [16*NPts-1:0] pts_fns;
    logic [NPts-1:0]    pts_valid;
    logic [31:0] tick_inc, ns_offset, pps_width;
    logic [47:0] sc_offset;
    logic        offset_valid, clear_rtc, intxms_sel, irq;

    int n_vec = 0;
    int n_err = 0;

    rtc_rgs_mc #(
        .BLK_ADDR   (Blk),
        .NUM_PTS    (NPts),
        .FIFO_DEPTH (Depth)
    ) dut (
        .bus2ip_clk     (clk),
        .bus2ip_rst_n   (rst_n),
        .bus2ip_addr_i  (addr),
        .bus2ip_data_i  (wdata),
        .bus2ip_rd_ce_i (rd_ce),
        .bus2ip_wr_ce_i (wr_ce),
        .ip2bus_data_o  (rdata),
        .rtc_std_i      (rtc_std),
        .rtc_fns_i      (rtc_fns),
        .pts_std_i      (pts_std),
        .pts_fns_i      (pts_fns),
        .pts_valid_i    (pts_valid),
        .tick_inc_o     (tick_inc),
        .ns_offset_o    (ns_offset),
        .sc_offset_o    (sc_offset),
        .offset_valid_o (offset_valid),
        .clear_rtc_o    (clear_rtc),
        .pps_width_o    (pps_width),
        .intxms_sel_o   (intxms_sel),
        .irq_o          (irq)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    ts_t         mq [2][$];
    ts_t         msh [2];
    ts_t         mcur;
    logic [1:0]  movf;
    logic [31:0] mtick, mns, mpps;
    logic [47:0] msc;
    logic [7:0]  men;
    logic        mintx;

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            mq[c].delete();
            msh[c] = '0;
        end
        mcur = '0; movf = '0; mtick = '0; mns = '0; mpps = '0; msc = '0; men = '0;
        mintx = 1'b0;
    endtask

    function automatic logic [7:0] model_stat();
        logic [7:0] s;
        s = '0;
        for (int c = 0; c < 2; c++) begin
            s[c]     = (mq[c].size() != 0);
            s[4 + c] = movf[c];
        end
        return s;
    endfunction

    // Expected read value for one read-start, applying its side effects to the model.
    task automatic model_read(input logic [7:0] off, output logic [31:0] e);
        int c;
        c = int'(off[4]);
        e = '0;
        case (off)
            8'h00: e = {29'b0, mintx, 2'b00};
            8'h04: e = mtick;
            8'h08: e = mns;
            8'h0C: e = {16'b0, msc[47:32]};
            8'h10: e = msc[31:0];
            8'h14: begin mcur = {rtc_std, rtc_fns}; e = mcur[95:64]; end
            8'h18: e = mcur[63:32];
            8'h1C: e = mcur[31:0];
            8'h20: e = mpps;
            8'h24: e = {24'b0, model_stat()};
            8'h28: e = {24'b0, men};
            8'h40, 8'h50: begin
                if (mq[c].size() != 0) begin
                    msh[c] = mq[c].pop_front();
                    e = msh[c][95:64];
                end
            end
            8'h44, 8'h54: e = msh[c][63:32];
            8'h48, 8'h58: e = msh[c][31:0];
            8'h4C, 8'h5C: e = {23'b0, movf[c], 3'b0, 5'(mq[c].size())};
            default: e = '0;
        endcase
    endtask

    task automatic model_write(input logic [7:0] off, input logic [31:0] d);
        case (off)
            8'h00: mintx = d[2];
            8'h04: mtick = d;
            8'h08: mns = d;
            8'h0C: msc[47:32] = d[15:0];
            8'h10: msc[31:0] = d;
            8'h20: mpps = d;
            8'h24: movf = movf & ~d[5:4];
            8'h28: men = d[7:0];
            default: ;
        endcase
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic ts_t rnd_ts();
        ts_t t;
        t = {$urandom(), $urandom(), $urandom()};
        return t;
    endfunction

    task automatic rd_a(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        addr = a; rd_ce = 1'b1;
        @(posedge clk);
        #1 d = rdata;
        @(negedge clk);
        rd_ce = 1'b0;
    endtask

    task automatic rd(input logic [7:0] off, output logic [31:0] d);
        rd_a({Blk, off}, d);
    endtask

    task automatic wr_a(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a; wdata = d; wr_ce = 1'b1;
        @(negedge clk);
        wr_ce = 1'b0;
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] d);
        wr_a({Blk, off}, d);
    endtask

    // One-cycle capture strobe on the channels in m; the model tracks the outcome.
    task automatic push(input logic [1:0] m, input ts_t t0, input ts_t t1);
        @(negedge clk);
        pts_std = {t1[95:16], t0[95:16]};
        pts_fns = {t1[15:0], t0[15:0]};
        pts_valid = m;
        for (int c = 0; c < 2; c++) begin
            if (m[c]) begin
                if (mq[c].size() == Depth) movf[c] = 1'b1;
                else mq[c].push_back(c == 0 ? t0 : t1);
            end
        end
        @(negedge clk);
        pts_valid = '0;
    endtask

    typedef struct {
        logic [7:0]  off;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;

    vec_t rst_tab [19];
    vec_t wr_tab  [11];
    logic [7:0] rd_offs [23];
    logic [7:0] wr_offs [11];

    initial begin
        logic [31:0] d, e;
        ts_t ev [6];
        logic [95:0] tmp;

        rst_tab = '{
            '{8'h00, 0, 0}, '{8'h04, 0, 0}, '{8'h08, 0, 0}, '{8'h0C, 0, 0}, '{8'h10, 0, 0},
            '{8'h14, 0, 0}, '{8'h18, 0, 0}, '{8'h1C, 0, 0}, '{8'h20, 0, 0}, '{8'h24, 0, 0},
            '{8'h28, 0, 0}, '{8'h40, 0, 0}, '{8'h44, 0, 0}, '{8'h48, 0, 0}, '{8'h4C, 0, 0},
            '{8'h50, 0, 0}, '{8'h5C, 0, 0}, '{8'h60, 0, 0}, '{8'h2C, 0, 0}};
        wr_tab = '{
            '{8'h04, 32'hDEADBEEF, 32'hDEADBEEF}, '{8'h08, 32'h3B9AC9FF, 32'h3B9AC9FF},
            '{8'h0C, 32'hABCD1234, 32'h00001234}, '{8'h10, 32'h89ABCDEF, 32'h89ABCDEF},
            '{8'h20, 32'h05F5E100, 32'h05F5E100}, '{8'h28, 32'h000001FE, 32'h000000FE},
            '{8'h28, 32'h00000000, 32'h00000000}, '{8'h2C, 32'hFFFFFFFF, 32'h00000000},
            '{8'h60, 32'hFFFFFFFF, 32'h00000000}, '{8'h4C, 32'hFFFFFFFF, 32'h00000000},
            '{8'h24, 32'h000000FF, 32'h00000000}};
        rd_offs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C, 8'h20, 8'h24,
                    8'h28, 8'h2C, 8'h40, 8'h44, 8'h48, 8'h4C, 8'h50, 8'h54, 8'h58, 8'h5C,
                    8'h60, 8'h6C, 8'h70};
        wr_offs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h20, 8'h24, 8'h28, 8'h2C, 8'h44,
                    8'h60};

        rst_n = 1'b0; addr = '0; wdata = '0; rd_ce = 1'b0; wr_ce = 1'b0;
        rtc_std = '0; rtc_fns = '0; pts_std = '0; pts_fns = '0; pts_valid = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset outputs.
        check("rst tick_inc", tick_inc, 0);
        check("rst ns_offset", ns_offset, 0);
        check("rst sc_offset", sc_offset, 0);
        check("rst pps_width", pps_width, 0);
        check("rst pulses", {offset_valid, clear_rtc, intxms_sel}, 0);
        check("rst irq", irq, 0);
        check("rst rdata", rdata, 0);

        // Every register reads zero after reset.
        for (int i = 0; i < 19; i++) begin
            rd(rst_tab[i].off, d);
            check($sformatf("rst_rd[%02h]", rst_tab[i].off), d, rst_tab[i].exp);
        end

        // Write then read back, including read-only and unmapped locations.
        for (int i = 0; i < 11; i++) begin
            wr(wr_tab[i].off, wr_tab[i].wd);
            rd(wr_tab[i].off, d);
            check($sformatf("wr_rd[%0d]@%02h", i, wr_tab[i].off), d, wr_tab[i].exp);
        end
        check("tick_inc_o", tick_inc, 32'hDEADBEEF);
        check("ns_offset_o", ns_offset, 32'h3B9AC9FF);
        check("sc_offset_o", sc_offset, 48'h1234_89ABCDEF);
        check("pps_width_o", pps_width, 32'h05F5E100);

        // A write outside the block base is ignored.
        wr_a({24'h00_C001, 8'h04}, 32'h0);
        rd(8'h04, d);
        check("foreign_blk_wr", d, 32'hDEADBEEF);

        // Same-cycle read and write: read returns the old value.
        @(negedge clk);
        addr = {Blk, 8'h04}; wdata = 32'h12345678; rd_ce = 1'b1; wr_ce = 1'b1;
        @(posedge clk);
        #1 check("rdwr_old", rdata, 32'hDEADBEEF);
        @(negedge clk);
        rd_ce = 1'b0; wr_ce = 1'b0;
        rd(8'h04, d);
        check("rdwr_new", d, 32'h12345678);

        // CTL pulses and self-clearing read-back.
        @(negedge clk);
        addr = {Blk, 8'h00}; wdata = 32'h7; wr_ce = 1'b1;
        @(posedge clk);
        #1 check("ctl_pulse_hi", {offset_valid, clear_rtc, intxms_sel}, 3'b111);
        @(negedge clk);
        wr_ce = 1'b0; rd_ce = 1'b1;
        @(posedge clk);
        #1 check("ctl_pulse_lo", {offset_valid, clear_rtc}, 2'b00);
        check("ctl_rd_next", rdata, 32'h7);
        @(negedge clk);
        rd_ce = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rd_ce = 1'b1;
        @(posedge clk);
        #1 check("ctl_rd_cleared", rdata, 32'h4);
        @(negedge clk);
        rd_ce = 1'b0;

        // Writing 0 to a pending bit does not clear it early.
        @(negedge clk);
        wdata = 32'h5; wr_ce = 1'b1;
        @(negedge clk);
        wdata = 32'h4; rd_ce = 1'b1;
        @(posedge clk);
        #1 check("ctl_w0_pre", rdata, 32'h5);
        @(negedge clk);
        wr_ce = 1'b0;
        @(posedge clk);
        #1 check("ctl_w0_pending", rdata, 32'h5);
        @(negedge clk);
        rd_ce = 1'b0;
        rd(8'h00, d);
        check("ctl_w0_final", d, 32'h4);

        // Coherent current-time snapshot.
        rtc_std = {48'h123456789ABC, 32'h11223344};
        rtc_fns = 16'h5566;
        rd(8'h14, d);
        check("cur_tm0", d, 32'h12345678);
        rtc_std = {48'hFFFF0000FFFF, 32'h0};
        rtc_fns = 16'hAAAA;
        rd(8'h18, d);
        check("cur_tm1", d, 32'h9ABC1122);
        rd(8'h1C, d);
        check("cur_tm2", d, 32'h33445566);

        // Channel 1: overflow, ordered pops, empty pop.
        for (int i = 0; i < 5; i++) begin
            ev[i] = {32'hA000_0000 + i, 32'hB000_0000 + i, 32'hC000_0000 + i};
            push(2'b10, '0, ev[i]);
        end
        rd(8'h5C, d);
        check("ch1_stat_ovf", d, 32'h104);
        rd(8'h24, d);
        check("irq_stat_ovf", d, 32'h22);
        for (int i = 0; i < 4; i++) begin
            rd(8'h50, d);
            check($sformatf("ch1_ts0[%0d]", i), d, ev[i][95:64]);
            rd(8'h54, d);
            check($sformatf("ch1_ts1[%0d]", i), d, ev[i][63:32]);
            rd(8'h58, d);
            check($sformatf("ch1_ts2[%0d]", i), d, ev[i][31:0]);
        end
        rd(8'h50, d);
        check("ch1_empty_ts0", d, 0);
        rd(8'h54, d);
        check("ch1_empty_shadow", d, ev[3][63:32]);
        rd(8'h5C, d);
        check("ch1_stat_drained", d, 32'h100);
        wr(8'h24, 32'h20);
        rd(8'h24, d);
        check("ovf_w1c", d, 0);

        // Interrupt timing on channel 0.
        wr(8'h28, 32'h1);
        ev[5] = rnd_ts();
        @(negedge clk);
        pts_std[79:0] = ev[5][95:16]; pts_fns[15:0] = ev[5][15:0]; pts_valid = 2'b01;
        @(posedge clk);
        #1 check("irq_not_yet", irq, 0);
        @(negedge clk);
        pts_valid = '0;
        @(posedge clk);
        #1 check("irq_set", irq, 1);
        rd(8'h40, d);
        check("irq_drain_ts0", d, ev[5][95:64]);
        @(posedge clk);
        #1 check("irq_clear", irq, 0);

        // Held read on TS0 pops exactly once.
        ev[0] = rnd_ts();
        ev[1] = rnd_ts();
        model_reset();
        push(2'b01, ev[0], '0);
        push(2'b01, ev[1], '0);
        @(negedge clk);
        addr = {Blk, 8'h40}; rd_ce = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("held_ts0", rdata, ev[0][95:64]);
        @(negedge clk);
        rd_ce = 1'b0;
        rd(8'h4C, d);
        check("held_level", d, 32'h1);
        rd(8'h40, d);
        check("held_next", d, ev[1][95:64]);

        // Push and pop together on a full FIFO.
        for (int i = 0; i < 5; i++) ev[i] = rnd_ts();
        for (int i = 0; i < 4; i++) push(2'b01, ev[i], '0);
        @(negedge clk);
        addr = {Blk, 8'h40}; rd_ce = 1'b1;
        pts_std[79:0] = ev[4][95:16]; pts_fns[15:0] = ev[4][15:0]; pts_valid = 2'b01;
        @(posedge clk);
        #1 check("full_pushpop_ts0", rdata, ev[0][95:64]);
        @(negedge clk);
        rd_ce = 1'b0; pts_valid = '0;
        rd(8'h4C, d);
        check("full_pushpop_stat", d, 32'h004);
        for (int i = 1; i < 5; i++) begin
            rd(8'h40, d);
            check($sformatf("full_drain[%0d]", i), d, ev[i][95:64]);
        end

        // Reset in the middle of a pending pulse, with FIFO contents present.
        push(2'b10, '0, rnd_ts());
        @(negedge clk);
        addr = {Blk, 8'h00}; wdata = 32'h1; wr_ce = 1'b1;
        @(posedge clk);
        #1 check("pre_rst_pulse", offset_valid, 1);
        #2 rst_n = 1'b0;
        #1 check("rst_cancels_pulse", offset_valid, 0);
        check("rst_clears_tick", tick_inc, 0);
        @(negedge clk);
        wr_ce = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        rd(8'h00, d);
        check("rst_ctl", d, 0);
        rd(8'h5C, d);
        check("rst_fifo_discard", d, 0);

        // Randomized traffic against the model.
        for (int it = 0; it < 400; it++) begin
            int op;
            op = $urandom_range(0, 9);
            if (op <= 2) begin
                push(2'($urandom_range(1, 3)), rnd_ts(), rnd_ts());
            end else if (op <= 6) begin
                logic [7:0] off;
                off = rd_offs[$urandom_range(0, 22)];
                tmp = rnd_ts();
                rtc_std = tmp[95:16];
                rtc_fns = tmp[15:0];
                model_read(off, e);
                rd(off, d);
                check($sformatf("rnd_rd[%0d]@%02h", it, off), d, e);
            end else if (op <= 8) begin
                logic [7:0] off;
                off = wr_offs[$urandom_range(0, 10)];
                d = $urandom();
                if (off == 8'h00) d = d & 32'h4;
                model_write(off, d);
                wr(off, d);
            end else begin
                repeat (2) @(posedge clk);
                #1 check($sformatf("rnd_irq[%0d]", it), irq, |(model_stat() & men));
                check($sformatf("rnd_outs[%0d]", it),
                      {tick_inc, intxms_sel}, {mtick, mintx});
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
